// File: rtl/run_controller.sv
// Run/stop/step policy for the monitored CPU clock domain: drives the cycle
// counter's pause, runs N-cycle steps and halts on an optional breakpoint.
module run_controller #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_req,
    input  logic             stop_req,
    input  logic             step_req,
    input  logic [WIDTH-1:0] step_count,
    input  logic             break_en,
    input  logic [WIDTH-1:0] break_count,
    input  logic [WIDTH-1:0] cycle_count,
    output logic             pause,
    output logic             running,
    output logic             done,
    output logic [1:0]       halt_cause,
    output logic [WIDTH-1:0] remaining
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_STOP  = 2'd1;
    localparam logic [1:0] CAUSE_STEP  = 2'd2;
    localparam logic [1:0] CAUSE_BREAK = 2'd3;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_nextState;
    logic             r_runPrev;
    logic             r_stopPrev;
    logic             r_stepPrev;
    logic             r_done;
    logic             w_nextDone;
    logic [1:0]       r_haltCause;
    logic [1:0]       w_nextHaltCause;
    logic [WIDTH-1:0] r_remaining;
    logic [WIDTH-1:0] w_nextRemaining;

    logic             w_runEdge;
    logic             w_stopEdge;
    logic             w_stepEdge;
    logic             w_breakHit;
    logic [WIDTH-1:0] w_countPlusOne;

    assign w_runEdge      = run_req  & ~r_runPrev;
    assign w_stopEdge     = stop_req & ~r_stopPrev;
    assign w_stepEdge     = step_req & ~r_stepPrev;
    // Compare against the value the counter is about to take so it stops on break_count.
    assign w_countPlusOne = cycle_count + ONE;
    assign w_breakHit     = break_en & (r_state != IDLE) & (w_countPlusOne == break_count);

    // Previous samples reset high so a request held through reset is not an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_runPrev  <= 1'b1;
            r_stopPrev <= 1'b1;
            r_stepPrev <= 1'b1;
        end else begin
            r_runPrev  <= run_req;
            r_stopPrev <= stop_req;
            r_stepPrev <= step_req;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_done      <= 1'b0;
            r_haltCause <= 2'd0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_nextState;
            r_done      <= w_nextDone;
            r_haltCause <= w_nextHaltCause;
            r_remaining <= w_nextRemaining;
        end
    end

    // Priority everywhere: stop > break > step-complete > step > run.
    always_comb begin
        w_nextState     = r_state;
        w_nextDone      = 1'b0;
        w_nextHaltCause = r_haltCause;
        w_nextRemaining = r_remaining;
        case (r_state)
            IDLE: begin
                if (w_stopEdge) begin
                    w_nextState = IDLE;
                end else if (w_stepEdge) begin
                    w_nextState     = STEP;
                    w_nextRemaining = (step_count == '0) ? ONE : step_count;
                end else if (w_runEdge) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_stopEdge) begin
                    w_nextState     = IDLE;
                    w_nextDone      = 1'b1;
                    w_nextHaltCause = CAUSE_STOP;
                end else if (w_breakHit) begin
                    w_nextState     = IDLE;
                    w_nextDone      = 1'b1;
                    w_nextHaltCause = CAUSE_BREAK;
                end
            end
            STEP: begin
                w_nextRemaining = r_remaining - ONE;
                if (w_stopEdge) begin
                    w_nextState     = IDLE;
                    w_nextDone      = 1'b1;
                    w_nextHaltCause = CAUSE_STOP;
                    w_nextRemaining = '0;
                end else if (w_breakHit) begin
                    w_nextState     = IDLE;
                    w_nextDone      = 1'b1;
                    w_nextHaltCause = CAUSE_BREAK;
                    w_nextRemaining = '0;
                end else if (r_remaining == ONE) begin
                    w_nextState     = IDLE;
                    w_nextDone      = 1'b1;
                    w_nextHaltCause = CAUSE_STEP;
                    w_nextRemaining = '0;
                end
            end
            default: begin
                w_nextState     = IDLE;
                w_nextRemaining = '0;
            end
        endcase
    end

    assign pause      = (r_state == IDLE);
    assign running    = ~pause;
    assign done       = r_done;
    assign halt_cause = r_haltCause;
    assign remaining  = r_remaining;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller, closed around a simple cycle counter
// that advances whenever pause is low.
module tb_run_controller;

    localparam int WIDTH = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             run_req = 1'b0;
    logic             stop_req = 1'b0;
    logic             step_req = 1'b0;
    logic [WIDTH-1:0] step_count = '0;
    logic             break_en = 1'b0;
    logic [WIDTH-1:0] break_count = '0;
    logic [WIDTH-1:0] cycle_count;
    logic             pause;
    logic             running;
    logic             done;
    logic [1:0]       halt_cause;
    logic [WIDTH-1:0] remaining;

    logic             loadEn = 1'b0;
    logic [WIDTH-1:0] loadValue = '0;

    int checks = 0;
    int errors = 0;

    run_controller #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .run_req     (run_req),
        .stop_req    (stop_req),
        .step_req    (step_req),
        .step_count  (step_count),
        .break_en    (break_en),
        .break_count (break_count),
        .cycle_count (cycle_count),
        .pause       (pause),
        .running     (running),
        .done        (done),
        .halt_cause  (halt_cause),
        .remaining   (remaining)
    );

    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset)
            cycle_count <= '0;
        else if (loadEn)
            cycle_count <= loadValue;
        else if (!pause)
            cycle_count <= cycle_count + 16'd1;
    end

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Called at a negedge; the request is seen at the next posedge and the task returns one negedge later.
    task automatic pulse(input int which);
        case (which)
            0: run_req = 1'b1;
            1: stop_req = 1'b1;
            default: step_req = 1'b1;
        endcase
        @(negedge clock);
        run_req  = 1'b0;
        stop_req = 1'b0;
        step_req = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic countUnpaused(input int limit, output int cycles);
        cycles = 0;
        while (pause === 1'b0 && cycles < limit) begin
            cycles++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (pause !== 1'b1) begin errors++; $display("FAIL reset_pause got %0b want 1", pause); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %0b want 0", running); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (halt_cause !== 2'd0) begin errors++; $display("FAIL reset_cause got %0d want 0", halt_cause); end
        checks++; if (remaining !== 16'd0) begin errors++; $display("FAIL reset_remaining got %0d want 0", remaining); end
    endtask

    task automatic test_step3();
        int cycles;
        step_count = 16'd3;
        pulse(2);
        for (int i = 0; i < 3; i++) begin
            checks++; if (pause !== 1'b0) begin errors++; $display("FAIL step3_pause[%0d] got %0b want 0", i, pause); end
            checks++; if (remaining !== 16'(3 - i)) begin errors++; $display("FAIL step3_remaining[%0d] got %0d want %0d", i, remaining, 3 - i); end
            @(negedge clock);
        end
        checks++; if (pause !== 1'b1) begin errors++; $display("FAIL step3_repause got %0b want 1", pause); end
        checks++; if (cycle_count !== 16'd3) begin errors++; $display("FAIL step3_count got %0d want 3", cycle_count); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL step3_done got %0b want 1", done); end
        checks++; if (halt_cause !== 2'd2) begin errors++; $display("FAIL step3_cause got %0d want 2", halt_cause); end
        checks++; if (remaining !== 16'd0) begin errors++; $display("FAIL step3_rem_end got %0d want 0", remaining); end
        @(negedge clock);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL step3_done_width got %0b want 0", done); end
        countUnpaused(5, cycles);
        checks++; if (cycle_count !== 16'd3) begin errors++; $display("FAIL step3_stays got %0d want 3", cycle_count); end
    endtask

    task automatic test_step0();
        int cycles;
        step_count = 16'd0;
        pulse(2);
        countUnpaused(10, cycles);
        checks++; if (cycles !== 1) begin errors++; $display("FAIL step0_cycles got %0d want 1", cycles); end
        checks++; if (cycle_count !== 16'd4) begin errors++; $display("FAIL step0_count got %0d want 4", cycle_count); end
        checks++; if (halt_cause !== 2'd2) begin errors++; $display("FAIL step0_cause got %0d want 2", halt_cause); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL step0_done got %0b want 1", done); end
    endtask

    task automatic test_run_stop();
        doReset();
        pulse(0);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running got %0b want 1", running); end
        waitCycles(9);
        pulse(1);
        checks++; if (pause !== 1'b1) begin errors++; $display("FAIL stop_pause got %0b want 1", pause); end
        checks++; if (cycle_count !== 16'd10) begin errors++; $display("FAIL stop_count got %0d want 10", cycle_count); end
        checks++; if (halt_cause !== 2'd1) begin errors++; $display("FAIL stop_cause got %0d want 1", halt_cause); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stop_done got %0b want 1", done); end
        @(negedge clock);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_done_width got %0b want 0", done); end
        checks++; if (cycle_count !== 16'd10) begin errors++; $display("FAIL stop_hold got %0d want 10", cycle_count); end
        pulse(0);
        checks++; if (cycle_count !== 16'd10) begin errors++; $display("FAIL resume_start got %0d want 10", cycle_count); end
        @(negedge clock);
        checks++; if (cycle_count !== 16'd11) begin errors++; $display("FAIL resume_step got %0d want 11", cycle_count); end
        pulse(1);
        checks++; if (cycle_count !== 16'd12) begin errors++; $display("FAIL resume_stop got %0d want 12", cycle_count); end
    endtask

    task automatic test_breakpoint();
        int cycles;
        doReset();
        break_en    = 1'b1;
        break_count = 16'h0020;
        pulse(0);
        countUnpaused(100, cycles);
        checks++; if (cycles !== 32) begin errors++; $display("FAIL brk_cycles got %0d want 32", cycles); end
        checks++; if (cycle_count !== 16'h0020) begin errors++; $display("FAIL brk_count got %h want 0020", cycle_count); end
        checks++; if (halt_cause !== 2'd3) begin errors++; $display("FAIL brk_cause got %0d want 3", halt_cause); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL brk_done got %0b want 1", done); end
        loadEn    = 1'b1;
        loadValue = 16'hFFF0;
        @(negedge clock);
        loadEn      = 1'b0;
        break_count = 16'h0000;
        pulse(0);
        countUnpaused(100, cycles);
        checks++; if (cycles !== 16) begin errors++; $display("FAIL wrap_cycles got %0d want 16", cycles); end
        checks++; if (cycle_count !== 16'h0000) begin errors++; $display("FAIL wrap_count got %h want 0000", cycle_count); end
        checks++; if (halt_cause !== 2'd3) begin errors++; $display("FAIL wrap_cause got %0d want 3", halt_cause); end
    endtask

    task automatic test_step_break();
        int cycles;
        doReset();
        break_en    = 1'b1;
        break_count = 16'd5;
        step_count  = 16'd100;
        pulse(2);
        countUnpaused(200, cycles);
        checks++; if (cycles !== 5) begin errors++; $display("FAIL stepbrk_cycles got %0d want 5", cycles); end
        checks++; if (cycle_count !== 16'd5) begin errors++; $display("FAIL stepbrk_count got %0d want 5", cycle_count); end
        checks++; if (halt_cause !== 2'd3) begin errors++; $display("FAIL stepbrk_cause got %0d want 3", halt_cause); end
        checks++; if (remaining !== 16'd0) begin errors++; $display("FAIL stepbrk_rem got %0d want 0", remaining); end
    endtask

    task automatic test_stop_vs_break();
        doReset();
        break_en    = 1'b1;
        break_count = 16'd5;
        pulse(0);
        waitCycles(4);
        pulse(1);
        checks++; if (pause !== 1'b1) begin errors++; $display("FAIL stopbrk_pause got %0b want 1", pause); end
        checks++; if (cycle_count !== 16'd5) begin errors++; $display("FAIL stopbrk_count got %0d want 5", cycle_count); end
        checks++; if (halt_cause !== 2'd1) begin errors++; $display("FAIL stopbrk_cause got %0d want 1", halt_cause); end
        break_en = 1'b0;
    endtask

    task automatic test_held_through_reset();
        step_count = 16'd4;
        step_req   = 1'b1;
        doReset();
        waitCycles(3);
        checks++; if (pause !== 1'b1) begin errors++; $display("FAIL held_pause got %0b want 1", pause); end
        checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL held_count got %0d want 0", cycle_count); end
        step_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid_run();
        int doneSeen;
        pulse(0);
        pulse(1);
        pulse(0);
        waitCycles(3);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL midrun_running got %0b want 1", running); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (pause !== 1'b1) begin errors++; $display("FAIL midrun_async_pause got %0b want 1", pause); end
        checks++; if (halt_cause !== 2'd0) begin errors++; $display("FAIL midrun_cause got %0d want 0", halt_cause); end
        @(negedge clock);
        reset = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) doneSeen++;
            @(negedge clock);
        end
        checks++; if (doneSeen !== 0) begin errors++; $display("FAIL midrun_done got %0d pulses want 0", doneSeen); end
    endtask

    initial begin
        test_reset();
        test_step3();
        test_step0();
        test_run_stop();
        test_breakpoint();
        test_step_break();
        test_stop_vs_break();
        test_held_through_reset();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Produces the pause control consumed by the cycle counter, and owns the run, stop and single/multi-step policy for the monitored CPU clock domain.
- Accepts run, stop and step requests from the monitor. For a step request it lets exactly N cycles elapse, then re-pauses.
- Optionally halts when the observed cycle count reaches a breakpoint value, and reports why it halted.

Parameters:
- WIDTH, 16, width of step_count, break_count, cycle_count and the internal remaining-cycles counter.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- run_req  input  1  request free-running; acts on rising edge.
- stop_req  input  1  request halt; acts on rising edge.
- step_req  input  1  request N-cycle step; acts on rising edge.
- step_count  input  WIDTH  cycles per step; sampled on the accepted step edge.
- break_en  input  1  enable breakpoint compare.
- break_count  input  WIDTH  breakpoint cycle value.
- cycle_count  input  WIDTH  current count from the cycle counter driven by this block's pause.
- pause  output  1  1 = counter/CPU held.
- running  output  1  1 in RUN or STEP.
- done  output  1  one-cycle pulse on each RUN/STEP -> IDLE transition.
- halt_cause  output  2  0 none, 1 stop, 2 step complete, 3 breakpoint; holds until the next halt.
- remaining  output  WIDTH  cycles left in the current step; 0 outside STEP.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clock. All request inputs are synchronous to clock (debounced upstream).
- Reset values: state IDLE, pause=1, running=0, done=0, halt_cause=0, remaining=0. The previous-sample registers for run/stop/step reset to 1, so a request held through reset is not taken as an edge.
- Edge detect: X_edge = X_req & ~X_prev. X_prev is updated every cycle.
- Output timing: pause = (state==IDLE) and running = ~pause, both decoded from registered state. The counter increments at every edge where pause=0.

State transitions, evaluated each edge:
- IDLE:
  - stop_edge: no effect.
  - else step_edge: go to STEP; remaining <= (step_count==0 ? 1 : step_count).
  - else run_edge: go to RUN.
- RUN:
  - stop_edge: go to IDLE, cause 1.
  - else break hit: go to IDLE, cause 3.
  - run_edge and step_edge are ignored.
- STEP, with remaining decremented each edge:
  - stop_edge: go to IDLE, cause 1.
  - else break hit: go to IDLE, cause 3.
  - else remaining==1: go to IDLE, cause 2.
  - run_edge and step_edge are ignored.
- Priority in all states: stop > break > step-complete > step > run.

Breakpoint:
- break hit = break_en & (state!=IDLE) & (cycle_count + 1 == break_count), computed modulo 2^WIDTH.
- Result: the counter stops holding exactly break_count.
- When break_count == cycle_count while in IDLE, a run proceeds and halts after 2^WIDTH cycles (wrap is intentional).

Step length and latency:
- Pause is low for exactly N consecutive cycles, starting the cycle after the accepted step edge.
- Stop latency is one cycle: the edge at which stop_edge is seen is the last counted edge.

Exit from RUN/STEP to IDLE:
- done=1 for one cycle, in the cycle pause first returns to 1.
- halt_cause is updated in that same cycle.
- remaining goes to 0.

Reset mid-operation forces IDLE immediately and asynchronously; pause=1 at once. No done pulse is produced.

Test Plan:
- Reset, then step_count=3 and pulse step_req with cycle_count fed from a real cycle counter -> pause low exactly 3 cycles; count 0->3; done pulses once; halt_cause=2; remaining 3,2,1,0.
- step_count=0, step_req -> exactly 1 cycle unpaused; count +1; halt_cause=2.
- run_req, then stop_req 10 cycles later -> count=10 after halt; halt_cause=1; done one cycle. A second run_req resumes from 10.
- break_en=1, break_count=0x0020, run_req -> counter halts at 0x0020, halt_cause=3. break_count=0x0000 from count 0xFFF0 -> halts at 0x0000 after wrap.
- step_count=100 with break_count=5 -> halts at 5, cause 3, remaining cleared. Simultaneous stop_req and breakpoint hit -> cause 1.
- step_req held high across reset deassert -> no step. Assert reset mid-RUN -> pause=1 asynchronously, halt_cause=0, no done pulse.
